// File: rtl/enc8x3_scan.sv
// rtl/enc8x3_scan.sv - sequential 8-to-3 encoder emitting one index per set request bit
// Optional macro ENC_COUNT_EN: registers the popcount of each accepted vector on vec_count.
module enc8x3_scan #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_vec,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [2:0] code,
   output logic       code_valid,
   input  logic       code_ready,
   output logic       code_last,
   output logic       zero_vec,
   output logic [3:0] vec_count
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t     state_q, state_d;
   logic [7:0] pending_q, pending_d;
   logic       zero_q, zero_d;
   logic [2:0] sel_idx;
   logic       sel_last;

   // Later loop iterations overwrite earlier ones, so the scan direction sets the priority.
   always_comb begin
      sel_idx = 3'd0;
      if (LSB_FIRST) begin
         for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = 3'(i);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) sel_idx = 3'(i);
         end
      end
   end

   assign sel_last = (pending_q != 8'h00) && ((pending_q & (pending_q - 8'd1)) == 8'h00);

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      zero_d     = 1'b0;
      in_ready   = 1'b0;
      code_valid = 1'b0;
      code       = 3'd0;
      code_last  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_vec != 8'h00) begin
                  pending_d = in_vec;
                  state_d   = SCAN;
               end else begin
                  zero_d = 1'b1;
               end
            end
         end
         SCAN: begin
            code_valid = 1'b1;
            code       = sel_idx;
            code_last  = sel_last;
            if (code_ready) begin
               pending_d = pending_q & ~(8'b1 << sel_idx);
               if (sel_last) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 8'h00;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         zero_q    <= zero_d;
      end
   end

   assign zero_vec = zero_q;

`ifdef ENC_COUNT_EN
   logic [3:0] count_q;
   logic [3:0] popcnt;

   always_comb begin
      popcnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         popcnt = popcnt + 4'(in_vec[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 4'd0;
      end else if (in_valid && in_ready) begin
         count_q <= popcnt;
      end
   end

   assign vec_count = count_q;
`else
   assign vec_count = 4'd0;
`endif

endmodule

// File: tb/tb_enc8x3_scan.sv
// tb/tb_enc8x3_scan.sv - randomized and directed bench for enc8x3_scan, both scan orders in lockstep
module tb_enc8x3_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_vec = 8'h00;
   logic       in_valid = 1'b0;
   logic       code_ready = 1'b0;

   logic       ir_l, cv_l, cl_l, zv_l, ir_m, cv_m, cl_m, zv_m;
   logic [2:0] cd_l, cd_m;
   logic [3:0] vc_l, vc_m;

   always #5 clk = ~clk;

   enc8x3_scan #(.LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir_l),
      .code(cd_l), .code_valid(cv_l), .code_ready(code_ready), .code_last(cl_l),
      .zero_vec(zv_l), .vec_count(vc_l)
   );

   enc8x3_scan #(.LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir_m),
      .code(cd_m), .code_valid(cv_m), .code_ready(code_ready), .code_last(cl_m),
      .zero_vec(zv_m), .vec_count(vc_m)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference: pending indices in emission order for each priority direction.
   int   q_l[$];
   int   q_m[$];
   bit   m_busy = 1'b0;
   bit   m_zero = 1'b0;
   int   m_count = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_count();
`ifdef ENC_COUNT_EN
      return m_count;
`else
      return 0;
`endif
   endfunction

   task automatic check_outputs();
      chk("in_ready_l", 32'(ir_l), 32'(!m_busy));
      chk("in_ready_m", 32'(ir_m), 32'(!m_busy));
      chk("code_valid_l", 32'(cv_l), 32'(m_busy));
      chk("code_valid_m", 32'(cv_m), 32'(m_busy));
      chk("code_l", 32'(cd_l), m_busy ? 32'(q_l[0]) : 32'd0);
      chk("code_m", 32'(cd_m), m_busy ? 32'(q_m[0]) : 32'd0);
      chk("code_last_l", 32'(cl_l), 32'(m_busy && q_l.size() == 1));
      chk("code_last_m", 32'(cl_m), 32'(m_busy && q_m.size() == 1));
      chk("zero_vec_l", 32'(zv_l), 32'(m_zero));
      chk("zero_vec_m", 32'(zv_m), 32'(m_zero));
      chk("vec_count_l", 32'(vc_l), 32'(exp_count()));
      chk("vec_count_m", 32'(vc_m), 32'(exp_count()));
   endtask

   // Drive one cycle of inputs, check outputs before the edge, advance the model on the edge.
   task automatic step(input logic [7:0] v, input logic vld, input logic rdy);
      bit acc, take;
      in_vec     = v;
      in_valid   = vld;
      code_ready = rdy;
      #1;
      check_outputs();
      acc  = vld && !m_busy;
      take = rdy && m_busy;
      @(posedge clk);
      m_zero = acc && (v == 8'h00);
      if (acc) begin
         m_count = $countones(v);
         for (int i = 0; i < 8; i++) if (v[i]) q_l.push_back(i);
         for (int i = 7; i >= 0; i--) if (v[i]) q_m.push_back(i);
         m_busy = (v != 8'h00);
      end
      if (take) begin
         void'(q_l.pop_front());
         void'(q_m.pop_front());
         if (q_l.size() == 0) m_busy = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      q_l.delete();
      q_m.delete();
      m_busy  = 1'b0;
      m_zero  = 1'b0;
      m_count = 0;
      chk("rst_code_valid", 32'(cv_l | cv_m), 32'd0);
      chk("rst_in_ready", 32'(ir_l & ir_m), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] rv;

   initial begin
      @(negedge clk);
      do_reset();
      check_outputs();

      // Reset in the middle of an 8'hFF scan, then confirm nothing further is emitted.
      step(8'hFF, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);

      // Three-bit vector with the consumer always ready.
      step(8'b1010_0100, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b1);

      // Full vector.
      step(8'hFF, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) step(8'h00, 1'b0, 1'b1);

      // All-zero vector: one-cycle zero_vec pulse only.
      step(8'h00, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b1);

      // Backpressure with a competing in_valid during the stalls.
      step(8'h81, 1'b1, 1'b0);
      step(8'h3C, 1'b1, 1'b0);
      step(8'h3C, 1'b1, 1'b0);
      step(8'h3C, 1'b1, 1'b1);
      step(8'h3C, 1'b1, 1'b0);
      step(8'h3C, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b1);

      // Single bit followed by a back-to-back vector.
      step(8'h10, 1'b1, 1'b1);
      step(8'h10, 1'b0, 1'b1);
      step(8'h06, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);

      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       rv = 8'h00;
            1:       rv = 8'(1 << $urandom_range(0, 7));
            default: rv = 8'($urandom);
         endcase
         step(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
